denise_sprite_mixer: RTL and testbench

//  Downstream of the eight sprite shifters. Merges their 2-bit serial pixels
//  and attach flags into one registered sprite pixel (colour index, pair

---
 rtl/denise_sprite_mixer_if.sv | 11 +
 rtl/denise_sprite_mixer.sv | 97 +++++++++
 tb/tb_denise_sprite_mixer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/denise_sprite_mixer_if.sv
// Register bus for the sprite mixer: CLXCON writes, CLXDAT reads, 7MHz qualifier.
interface denise_sprite_mixer_if;
   logic        clk7_en;
   logic        clxcon_wr;
   logic        clxdat_rd;
   logic [15:0] data_in;
   logic [15:0] clxdat;

   modport master (output clk7_en, clxcon_wr, clxdat_rd, data_in, input clxdat);
   modport slave  (input clk7_en, clxcon_wr, clxdat_rd, data_in, output clxdat);
endinterface

// File: rtl/denise_sprite_mixer.sv
// Sprite pixel merge (4 pairs, lowest pair wins) and CLXCON/CLXDAT collision latch.
module denise_sprite_mixer (
   input  logic                 clk,
   input  logic                 reset,
   denise_sprite_mixer_if.slave bus,
   input  logic [15:0]          sprdata,
   input  logic [7:0]           attach,
   input  logic                 pf1_match,
   input  logic                 pf2_match,
   input  logic                 clx_en,
   output logic                 spr_nz,
   output logic [1:0]           spr_pair,
   output logic [3:0]           spr_color
);

   logic [3:0]       ensp;       // ENSP7,5,3,1 -> bits 3..0
   logic [14:0]      latch;
   logic [3:0]       pair_nz;
   logic [3:0][3:0]  pair_col;
   logic [3:0]       grp;
   logic [14:0]      hits;
   logic             nz_d;
   logic [1:0]       pair_d;
   logic [3:0]       col_d;

   // Even-sprite attach bits and CLXCON low bits are not consumed here.
   logic unused_bits;
   assign unused_bits = ^{attach[6], attach[4], attach[2], attach[0], bus.data_in[11:0]};

   // Per-pair colour select and collision group membership.
   for (genvar p = 0; p < 4; p++) begin : g_pair
      logic [1:0] ev, od;
      assign ev          = sprdata[4*p +: 2];
      assign od          = sprdata[4*p+2 +: 2];
      assign pair_nz[p]  = |{ev, od};
      assign pair_col[p] = attach[2*p+1] ? {od, ev} :
                           (|ev)         ? {2'(p), ev} : {2'(p), od};
      assign grp[p]      = (|ev) | (ensp[p] & (|od));
   end

   // Lowest-numbered nonzero pair wins; scan high to low so low overrides.
   always_comb begin
      nz_d   = 1'b0;
      pair_d = 2'd0;
      col_d  = 4'd0;
      for (int p = 3; p >= 0; p--) begin
         if (pair_nz[p]) begin
            nz_d   = 1'b1;
            pair_d = 2'(p);
            col_d  = pair_col[p];
         end
      end
   end

   // Collision conditions in CLXDAT bit order, gated by the qualifier.
   assign hits = {15{clx_en}} & {
      grp[2] & grp[3], grp[1] & grp[3], grp[1] & grp[2],
      grp[0] & grp[3], grp[0] & grp[2], grp[0] & grp[1],
      {4{pf2_match}} & grp,
      {4{pf1_match}} & grp,
      pf1_match & pf2_match
   };

   assign bus.clxdat = {1'b1, latch};

   // Registered sprite pixel, one clk latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spr_nz    <= 1'b0;
         spr_pair  <= 2'd0;
         spr_color <= 4'd0;
      end else begin
         spr_nz    <= nz_d;
         spr_pair  <= pair_d;
         spr_color <= col_d;
      end
   end

   // CLXCON enable bits; a write takes effect from the following clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ensp <= 4'd0;
      else if (bus.clk7_en && bus.clxcon_wr)
         ensp <= bus.data_in[15:12];
   end

   // Sticky collision latch; clear-on-read, with new hits surviving the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         latch <= 15'd0;
      else if (bus.clk7_en && bus.clxdat_rd)
         latch <= hits;
      else
         latch <= latch | hits;
   end

endmodule

// File: tb/tb_denise_sprite_mixer.sv
// Scoreboard bench for denise_sprite_mixer: directed cases plus random traffic.
module tb_denise_sprite_mixer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] sprdata = '0;
   logic [7:0]  attach = '0;
   logic        pf1_match = 1'b0, pf2_match = 1'b0, clx_en = 1'b0;
   logic        spr_nz;
   logic [1:0]  spr_pair;
   logic [3:0]  spr_color;

   denise_sprite_mixer_if bus ();

   denise_sprite_mixer dut (
      .clk(clk), .reset(reset), .bus(bus),
      .sprdata(sprdata), .attach(attach),
      .pf1_match(pf1_match), .pf2_match(pf2_match), .clx_en(clx_en),
      .spr_nz(spr_nz), .spr_pair(spr_pair), .spr_color(spr_color)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        nz;
      logic [1:0]  pair;
      logic [3:0]  color;
      logic [15:0] clxdat;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic [14:0] m_latch = '0;
   logic [3:0]  m_ensp = '0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: apply the pixel and collision rules to one clk of inputs.
   task automatic drive(input logic [15:0] spr, input logic [7:0] att,
                        input logic p1, input logic p2, input logic ce,
                        input logic en, input logic wr, input logic rd,
                        input logic [15:0] din);
      exp_t        e;
      logic [1:0]  ev, od;
      logic [3:0]  g;
      logic [14:0] h;
      bit          found;
      int          k;
      @(negedge clk);
      sprdata = spr; attach = att; pf1_match = p1; pf2_match = p2; clx_en = ce;
      bus.clk7_en = en; bus.clxcon_wr = wr; bus.clxdat_rd = rd; bus.data_in = din;
      e.nz = 0; e.pair = 0; e.color = 0; found = 0;
      for (int p = 0; p < 4; p++) begin
         ev = spr[4*p +: 2];
         od = spr[4*p+2 +: 2];
         g[p] = (ev != 0) || (m_ensp[p] && od != 0);
         if (!found && (ev != 0 || od != 0)) begin
            found   = 1;
            e.nz    = 1;
            e.pair  = 2'(p);
            if (att[2*p+1])   e.color = 4'(od * 4 + ev);
            else if (ev != 0) e.color = 4'(p * 4 + ev);
            else              e.color = 4'(p * 4 + od);
         end
      end
      h = '0;
      h[0] = p1 & p2;
      for (int p = 0; p < 4; p++) begin
         h[1+p] = p1 & g[p];
         h[5+p] = p2 & g[p];
      end
      k = 9;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++) begin
            h[k] = g[i] & g[j];
            k++;
         end
      if (!ce) h = '0;
      if (en && rd) m_latch = '0;
      m_latch = m_latch | h;
      if (en && wr) m_ensp = din[15:12];
      e.clxdat = {1'b1, m_latch};
      q.push_back(e);
   endtask

   task automatic idle();
      drive(16'h0, 8'h0, 0, 0, 0, 0, 0, 0, 16'h0);
   endtask

   // Directed constant check just after the edge that consumed the last drive.
   task automatic dchk(input string nm, input logic [15:0] act_sel, input logic [15:0] req);
      chk(nm, act_sel, req);
   endtask

   // Monitor: every clk the DUT presents a pixel; compare against the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!reset && q.size() > 0) begin
         e = q.pop_front();
         chk("spr_nz",    {15'd0, spr_nz},    {15'd0, e.nz});
         chk("spr_pair",  {14'd0, spr_pair},  {14'd0, e.pair});
         chk("spr_color", {12'd0, spr_color}, {12'd0, e.color});
         chk("clxdat",    bus.clxdat,         e.clxdat);
      end
   end

   initial begin
      bus.clk7_en = 0; bus.clxcon_wr = 0; bus.clxdat_rd = 0; bus.data_in = '0;
      #12;
      chk("reset_nz",     {15'd0, spr_nz},    16'd0);
      chk("reset_color",  {12'd0, spr_color}, 16'd0);
      chk("reset_clxdat", bus.clxdat,         16'h8000);
      @(negedge clk); reset = 0;

      // Priority
      drive(16'h0C04, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("prio_pair0", {14'd0, spr_pair}, 16'd0);
      dchk("prio_col0",  {12'd0, spr_color}, 16'h1);
      drive(16'h0C00, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("prio_pair2", {14'd0, spr_pair}, 16'd2);
      dchk("prio_col2",  {12'd0, spr_color}, 16'hB);

      // Attach
      drive(16'h0006, 8'h02, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("att_nz",  {15'd0, spr_nz},    16'd1);
      dchk("att_col", {12'd0, spr_color}, 16'h6);
      drive(16'h0006, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("unatt_col", {12'd0, spr_color}, 16'h2);

      // Collision and clear-on-read
      drive(16'h0011, 8'h00, 0, 0, 1, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("clx_b9", bus.clxdat, 16'h8200);
      drive(16'h0000, 8'h00, 0, 0, 0, 1, 0, 1, 0);
      @(posedge clk); #2;
      dchk("clx_clear", bus.clxdat, 16'h8000);

      // ENSP
      drive(16'h0000, 8'h00, 0, 0, 0, 1, 1, 0, 16'h1000);
      drive(16'h0014, 8'h00, 0, 0, 1, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("ensp1_b9", bus.clxdat, 16'h8200);
      drive(16'h0000, 8'h00, 0, 0, 0, 1, 1, 1, 16'h0000);
      drive(16'h0014, 8'h00, 0, 0, 1, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("ensp0_none", bus.clxdat, 16'h8000);
      drive(16'h1000, 8'h00, 1, 0, 1, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("pf1_spr6_b4", bus.clxdat, 16'h8010);

      // Set wins over clear; clx_en=0 holds
      drive(16'h1100, 8'h00, 0, 0, 1, 1, 0, 1, 0);
      @(posedge clk); #2;
      dchk("set_vs_clear", bus.clxdat, 16'hC000);
      drive(16'h1111, 8'h00, 1, 1, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      dchk("clx_en_off", bus.clxdat, 16'hC000);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [15:0] r;
         r = 16'($urandom);
         if ($urandom_range(0, 3) == 0) r = r & 16'($urandom);
         drive(r, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 5) == 0), 16'($urandom));
      end

      // Mid-frame async reset
      drive(16'h0404, 8'h00, 1, 1, 1, 0, 0, 0, 0);
      idle();
      @(posedge clk); #3;
      reset = 1;
      #1;
      chk("midreset_nz",     {15'd0, spr_nz},    16'd0);
      chk("midreset_color",  {12'd0, spr_color}, 16'd0);
      chk("midreset_clxdat", bus.clxdat,         16'h8000);
      m_latch = '0; m_ensp = '0;
      @(negedge clk); @(negedge clk); reset = 0;
      drive(16'h0030, 8'h00, 0, 1, 1, 0, 0, 0, 0);
      drive(16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
